// File: rtl/calc_cmd_arb.sv
// calc_cmd_arb
//   Round-robin command arbiter in front of the stack calculator core.
//   Two requesters (A = front panel, B = host) offer 2-bit commands with an
//   8-bit operand. Each granted command becomes exactly one single-cycle
//   pulse on the core's sw/btn inputs. Further grants are then held off for
//   a per-command guard interval, so multi-cycle core operations finish first.
//
// Parameters
//   BASIC_GUARD : idle cycles after PUSH/APPEND/CLEAR (0 allowed)
//   OP_GUARD    : idle cycles after OP (>= 1, covers worst-case divide)
//   GUARD_W     : guard counter width, both guards < 2**GUARD_W
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   a_valid/a_cmd/a_data/a_ready : panel requester handshake
//   b_valid/b_cmd/b_data/b_ready : host requester handshake
//   disp_hi           : display half select, shown on btn[0] between pulses
//   sw, btn           : core switch/button inputs (registered pulse)
//   busy              : high while issuing or guarding
//   last_src          : source of most recent grant (0 = A, 1 = B)
module calc_cmd_arb #(
    parameter int BASIC_GUARD = 2,
    parameter int OP_GUARD    = 40,
    parameter int GUARD_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic [1:0] a_cmd,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [1:0] b_cmd,
    input  logic [7:0] b_data,
    output logic       b_ready,
    input  logic       disp_hi,
    output logic [7:0] sw,
    output logic [3:0] btn,
    output logic       busy,
    output logic       last_src
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD
    } state_t;

    typedef enum logic [1:0] {
        CMD_PUSH   = 2'b00,
        CMD_APPEND = 2'b01,
        CMD_OP     = 2'b10,
        CMD_CLEAR  = 2'b11
    } cmd_t;

    localparam logic [GUARD_W-1:0] BASIC_G = GUARD_W'(BASIC_GUARD);
    localparam logic [GUARD_W-1:0] OP_G    = GUARD_W'(OP_GUARD);

    state_t             state_q, state_d;
    logic [GUARD_W-1:0] cnt_q, cnt_d;
    logic               last_src_q, last_src_d;
    logic [7:0]         sw_q, sw_d;
    logic [3:0]         pulse_q, pulse_d;
    logic               busy_q, busy_d;

    logic               grant_a, grant_b;
    cmd_t               sel_cmd;
    logic [7:0]         sel_data;

    // Grant: a lone requester wins; on a tie the one not granted last wins.
    // Gated by rst so both readies stay low while reset is asserted.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == S_IDLE && !rst) begin
            grant_a = a_valid & (~b_valid | last_src_q);
            grant_b = b_valid & (~a_valid | ~last_src_q);
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;

    assign sel_cmd  = cmd_t'(grant_b ? b_cmd : a_cmd);
    assign sel_data = grant_b ? b_data : a_data;

    // The counter is loaded with the full guard G at transfer; the ISSUE
    // cycle decides between IDLE (G = 0) and GUARD with G-1, so GUARD lasts
    // exactly G cycles and leaves on the cycle the counter reads zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_src_d = last_src_q;
        sw_d       = '0;
        pulse_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_a || grant_b) begin
                    state_d    = S_ISSUE;
                    last_src_d = grant_b;
                    cnt_d      = (sel_cmd == CMD_OP) ? OP_G : BASIC_G;
                    case (sel_cmd)
                        CMD_PUSH: begin
                            pulse_d = 4'b0010;
                            sw_d    = sel_data;
                        end
                        CMD_APPEND: begin
                            pulse_d = 4'b0100;
                            sw_d    = sel_data;
                        end
                        CMD_OP: begin
                            // btn[0] low so the core never sees a clear here
                            pulse_d = 4'b1000;
                            sw_d    = {5'b00000, sel_data[2:0]};
                        end
                        CMD_CLEAR: begin
                            pulse_d = 4'b1001;
                            sw_d    = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_ISSUE: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GUARD;
                    cnt_d   = cnt_q - GUARD_W'(1);
                end
            end
            S_GUARD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - GUARD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_src_q <= 1'b0;
            sw_q       <= '0;
            pulse_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_src_q <= last_src_d;
            sw_q       <= sw_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
        end
    end

    // Every command pulse is non-zero, so an all-zero pulse register means
    // "not issuing" and btn falls back to the display select.
    assign btn      = (pulse_q != '0) ? pulse_q : {3'b000, disp_hi};
    assign sw       = sw_q;
    assign busy     = busy_q;
    assign last_src = last_src_q;

endmodule

// File: tb/tb_calc_cmd_arb.sv
module tb_calc_cmd_arb;

    localparam int P_BASIC = 2;
    localparam int P_OP    = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid, b_valid, disp_hi;
    logic [1:0] a_cmd, b_cmd;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, busy, last_src;
    logic [7:0] sw;
    logic [3:0] btn;

    // second instance with a zero basic guard
    logic       z_a_valid, z_b_valid;
    logic [1:0] z_a_cmd, z_b_cmd;
    logic [7:0] z_a_data, z_b_data;
    logic       z_a_ready, z_b_ready, z_busy, z_last_src;
    logic [7:0] z_sw;
    logic [3:0] z_btn;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    calc_cmd_arb #(.BASIC_GUARD(P_BASIC), .OP_GUARD(P_OP), .GUARD_W(8)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_cmd(a_cmd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_cmd(b_cmd), .b_data(b_data), .b_ready(b_ready),
        .disp_hi(disp_hi), .sw(sw), .btn(btn), .busy(busy), .last_src(last_src)
    );

    calc_cmd_arb #(.BASIC_GUARD(0), .OP_GUARD(P_OP), .GUARD_W(8)) dut0 (
        .clk(clk), .rst(rst),
        .a_valid(z_a_valid), .a_cmd(z_a_cmd), .a_data(z_a_data), .a_ready(z_a_ready),
        .b_valid(z_b_valid), .b_cmd(z_b_cmd), .b_data(z_b_data), .b_ready(z_b_ready),
        .disp_hi(1'b0), .sw(z_sw), .btn(z_btn), .busy(z_busy), .last_src(z_last_src)
    );

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reset both instances; returns 1 time unit into cycle 0 with rst low
    task automatic do_reset();
        a_valid = 0; a_cmd = 0; a_data = 0;
        b_valid = 0; b_cmd = 0; b_data = 0;
        z_a_valid = 0; z_a_cmd = 0; z_a_data = 0;
        z_b_valid = 0; z_b_cmd = 0; z_b_data = 0;
        disp_hi = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        a_valid = 1; b_valid = 1; disp_hi = 1;
        rst = 1;
        #3;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready got=%b exp=0", a_ready); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready got=%b exp=0", b_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (sw !== 8'h00) begin errors++; $display("FAIL rst_sw got=%h exp=00", sw); end
        checks++; if (btn !== 4'b0001) begin errors++; $display("FAIL rst_btn_hi got=%b exp=0001", btn); end
        checks++; if (last_src !== 1'b0) begin errors++; $display("FAIL rst_last_src got=%b exp=0", last_src); end
        disp_hi = 0;
        #1;
        checks++; if (btn !== 4'b0000) begin errors++; $display("FAIL rst_btn_lo got=%b exp=0000", btn); end
    endtask

    task automatic test_single_push();
        do_reset();
        a_valid = 1; a_cmd = 2'b00; a_data = 8'h5A;
        #3;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL push_a_ready got=%b exp=1", a_ready); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL push_b_ready got=%b exp=0", b_ready); end
        tick();
        a_valid = 0;
        #3;
        checks++; if (btn !== 4'b0010 || sw !== 8'h5A) begin errors++; $display("FAIL push_pulse got btn=%b sw=%h exp btn=0010 sw=5a", btn, sw); end
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) begin
                checks++; if (btn !== 4'b0000 || sw !== 8'h00) begin errors++; $display("FAIL push_after cyc=%0d got btn=%b sw=%h exp 0000/00", c, btn, sw); end
            end
            checks++; if (busy !== (c <= 3)) begin errors++; $display("FAIL push_busy cyc=%0d got=%b exp=%b", c, busy, (c <= 3)); end
            tick();
            #3;
        end
    endtask

    task automatic test_divide_guard();
        int c;
        int low_cnt;
        do_reset();
        disp_hi = 1;
        b_valid = 1; b_cmd = 2'b10; b_data = 8'h03;
        #3;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL div_b_ready got=%b exp=1", b_ready); end
        tick();
        #3;
        checks++; if (btn !== 4'b1000 || sw !== 8'h03) begin errors++; $display("FAIL div_pulse got btn=%b sw=%h exp btn=1000 sw=03", btn, sw); end
        c = 1;
        low_cnt = 0;
        while (b_ready !== 1'b1 && c < 100) begin
            low_cnt++;
            if (c == 2) begin
                checks++; if (btn !== 4'b0001 || sw !== 8'h00) begin errors++; $display("FAIL div_guard_out got btn=%b sw=%h exp 0001/00", btn, sw); end
            end
            tick();
            c++;
            #3;
        end
        checks++; if (c !== 42) begin errors++; $display("FAIL div_next_grant got cycle=%0d exp=42", c); end
        checks++; if (low_cnt !== 41) begin errors++; $display("FAIL div_ready_low got=%0d exp=41", low_cnt); end
        tick();
        b_valid = 0;
    endtask

    task automatic test_contention();
        int pc[$];
        logic [7:0] psw[$];
        logic pls[$];
        do_reset();
        a_valid = 1; a_cmd = 2'b00; a_data = 8'h11;
        b_valid = 1; b_cmd = 2'b00; b_data = 8'h22;
        for (int c = 0; c < 16; c++) begin
            #3;
            if (c == 0) begin
                checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL cont_first_tie got a=%b b=%b exp a=0 b=1", a_ready, b_ready); end
            end
            if (btn == 4'b0010) begin
                pc.push_back(c);
                psw.push_back(sw);
                pls.push_back(last_src);
            end
            tick();
        end
        checks++; if (pc.size() !== 4) begin errors++; $display("FAIL cont_count got=%0d exp=4", pc.size()); end
        for (int k = 0; k < 4 && k < pc.size(); k++) begin
            checks++; if (pc[k] !== 1 + 4 * k) begin errors++; $display("FAIL cont_cycle k=%0d got=%0d exp=%0d", k, pc[k], 1 + 4 * k); end
            checks++; if (psw[k] !== ((k % 2 == 0) ? 8'h22 : 8'h11)) begin errors++; $display("FAIL cont_sw k=%0d got=%h", k, psw[k]); end
            checks++; if (pls[k] !== (k % 2 == 0)) begin errors++; $display("FAIL cont_last_src k=%0d got=%b exp=%b", k, pls[k], (k % 2 == 0)); end
        end
        a_valid = 0; b_valid = 0;
    endtask

    task automatic test_clear();
        int n;
        do_reset();
        a_valid = 1; a_cmd = 2'b11; a_data = 8'hFF;
        #3;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL clr_a_ready got=%b exp=1", a_ready); end
        tick();
        a_valid = 0;
        #3;
        checks++; if (btn !== 4'b1001 || sw !== 8'h00) begin errors++; $display("FAIL clr_pulse got btn=%b sw=%h exp 1001/00", btn, sw); end
        n = 0;
        for (int c = 1; c < 8; c++) begin
            if (btn == 4'b1001) n++;
            tick();
            #3;
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL clr_pulse_count got=%0d exp=1", n); end
    endtask

    task automatic test_reset_mid_guard();
        do_reset();
        b_valid = 1; b_cmd = 2'b10; b_data = 8'h05;
        tick();
        b_valid = 0;
        for (int c = 1; c < 12; c++) tick();
        #1;
        checks++; if (busy !== 1'b1 || last_src !== 1'b1) begin errors++; $display("FAIL mid_pre got busy=%b last_src=%b exp 1/1", busy, last_src); end
        a_valid = 1; a_cmd = 2'b00; a_data = 8'h3C; disp_hi = 0;
        rst = 1;
        #1;
        checks++; if (busy !== 1'b0 || btn !== 4'b0000 || sw !== 8'h00) begin errors++; $display("FAIL mid_abort got busy=%b btn=%b sw=%h exp 0/0000/00", busy, btn, sw); end
        checks++; if (a_ready !== 1'b0 || last_src !== 1'b0) begin errors++; $display("FAIL mid_rst_state got a_ready=%b last_src=%b exp 0/0", a_ready, last_src); end
        tick();
        rst = 0;
        #3;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL mid_regrant got=%b exp=1", a_ready); end
        tick();
        a_valid = 0;
        #3;
        checks++; if (btn !== 4'b0010 || sw !== 8'h3C) begin errors++; $display("FAIL mid_push got btn=%b sw=%h exp 0010/3c", btn, sw); end
        for (int c = 0; c < 6; c++) begin
            tick();
            #3;
            checks++; if (btn === 4'b1000) begin errors++; $display("FAIL mid_replay got btn=%b exp not 1000", btn); end
        end
    endtask

    task automatic test_zero_guard();
        logic [7:0] dat[3];
        logic [1:0] cmd[3];
        dat[0] = 8'h00; dat[1] = 8'h01; dat[2] = 8'h02;
        cmd[0] = 2'b00; cmd[1] = 2'b01; cmd[2] = 2'b01;
        do_reset();
        z_a_valid = 1;
        for (int k = 0; k < 3; k++) begin
            z_a_cmd = cmd[k]; z_a_data = dat[k];
            #3;
            checks++; if (z_a_ready !== 1'b1 || z_busy !== 1'b0) begin errors++; $display("FAIL zg_ready k=%0d got ready=%b busy=%b exp 1/0", k, z_a_ready, z_busy); end
            tick();
            if (k == 2) z_a_valid = 0;
            else begin z_a_cmd = cmd[k + 1]; z_a_data = dat[k + 1]; end
            #3;
            checks++; if (z_btn !== ((k == 0) ? 4'b0010 : 4'b0100) || z_sw !== dat[k]) begin errors++; $display("FAIL zg_pulse k=%0d got btn=%b sw=%h", k, z_btn, z_sw); end
            checks++; if (z_a_ready !== 1'b0) begin errors++; $display("FAIL zg_issue_ready k=%0d got=%b exp=0", k, z_a_ready); end
            tick();
        end
        #3;
        checks++; if (z_busy !== 1'b0 || z_btn !== 4'b0000) begin errors++; $display("FAIL zg_end got busy=%b btn=%b exp 0/0000", z_busy, z_btn); end
    endtask

    // Reference: free-running cycle numbers; a transfer at cycle T means a
    // pulse at T+1 and IDLE again from T+2+G.
    task automatic test_random();
        int m_idle_from, m_pulse_cyc, g, r;
        logic m_last, idle, exp_ar, exp_br;
        logic [3:0] m_pbtn, exp_btn;
        logic [7:0] m_psw, exp_sw, tdata;
        logic [1:0] tcmd;
        do_reset();
        m_idle_from = 0; m_pulse_cyc = -1; m_last = 0; m_pbtn = 0; m_psw = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            a_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 7);
            a_cmd = (r == 0) ? 2'b10 : (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : 2'b11;
            a_data = 8'($urandom);
            b_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 7);
            b_cmd = (r == 0) ? 2'b10 : (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : 2'b11;
            b_data = 8'($urandom);
            disp_hi = 1'($urandom_range(0, 1));
            #3;
            idle = (cyc >= m_idle_from);
            exp_ar = idle && a_valid && (!b_valid || m_last);
            exp_br = idle && b_valid && (!a_valid || !m_last);
            if (cyc == m_pulse_cyc) begin exp_btn = m_pbtn; exp_sw = m_psw; end
            else begin exp_btn = {3'b000, disp_hi}; exp_sw = 8'h00; end
            checks++; if (a_ready !== exp_ar) begin errors++; $display("FAIL rnd_a_ready cyc=%0d got=%b exp=%b", cyc, a_ready, exp_ar); end
            checks++; if (b_ready !== exp_br) begin errors++; $display("FAIL rnd_b_ready cyc=%0d got=%b exp=%b", cyc, b_ready, exp_br); end
            checks++; if (busy !== !idle) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, !idle); end
            checks++; if (last_src !== m_last) begin errors++; $display("FAIL rnd_last_src cyc=%0d got=%b exp=%b", cyc, last_src, m_last); end
            checks++; if (btn !== exp_btn || sw !== exp_sw) begin errors++; $display("FAIL rnd_out cyc=%0d got btn=%b sw=%h exp btn=%b sw=%h", cyc, btn, sw, exp_btn, exp_sw); end
            if (exp_ar || exp_br) begin
                tcmd = exp_br ? b_cmd : a_cmd;
                tdata = exp_br ? b_data : a_data;
                m_last = exp_br;
                g = (tcmd == 2'b10) ? P_OP : P_BASIC;
                m_pulse_cyc = cyc + 1;
                m_idle_from = cyc + 2 + g;
                case (tcmd)
                    2'b00: begin m_pbtn = 4'b0010; m_psw = tdata; end
                    2'b01: begin m_pbtn = 4'b0100; m_psw = tdata; end
                    2'b10: begin m_pbtn = 4'b1000; m_psw = {5'b00000, tdata[2:0]}; end
                    default: begin m_pbtn = 4'b1001; m_psw = 8'h00; end
                endcase
            end
            tick();
        end
        a_valid = 0; b_valid = 0;
    endtask

    initial begin
        a_valid = 0; a_cmd = 0; a_data = 0;
        b_valid = 0; b_cmd = 0; b_data = 0;
        z_a_valid = 0; z_a_cmd = 0; z_a_data = 0;
        z_b_valid = 0; z_b_cmd = 0; z_b_data = 0;
        disp_hi = 0;
        tick();
        test_reset();
        test_single_push();
        test_divide_guard();
        test_contention();
        test_clear();
        test_reset_mid_guard();
        test_zero_guard();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
